// File: rtl/filter_apb_mst_pkg.sv
// Shared types and constants for the filter_apb_mst APB initiator.
package filter_apb_mst_pkg;

    localparam int unsigned APB_ADDR_W          = 8;
    localparam int unsigned APB_DATA_W          = 32;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/filter_apb_reg_pkg.sv
// Register map of the APB target reached through filter_apb_mst.
package filter_apb_reg_pkg;

    localparam logic [7:0] CTRL_ADDR = 8'h10;
    localparam logic [7:0] DATA_ADDR = 8'h20;
    localparam logic [7:0] ERR_ADDR  = 8'h54;
    localparam logic [7:0] ID_ADDR   = 8'hFC;

endpackage

// File: rtl/filter_apb_mst.sv
// Single-outstanding APB initiator: turns one command into one APB transfer
// and returns one response.
// Optional access timeout is enabled by defining FILTER_APB_MST_TIMEOUT_EN.
module filter_apb_mst
    import filter_apb_mst_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB initiator
    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy
);

    state_e                  state_q, state_d;
    logic                    rst_done_q;
    logic                    write_q, write_d;
    logic [APB_ADDR_W-1:0]   addr_q, addr_d;
    logic [APB_DATA_W-1:0]   wdata_q, wdata_d;
    logic [APB_DATA_W-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    accept;
    logic                    misaligned;
    logic                    tmo_hit;

    assign accept     = cmd_valid & cmd_ready;
    assign misaligned = (cmd_addr[1:0] != 2'b00);

`ifdef FILTER_APB_MST_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;

    assign tmo_hit = (state_q == ACCESS) && !pready && (cnt_q == 8'(TIMEOUT_CYC - 1));

    // Wait-state counter: cleared while entering ACCESS, counts pready=0 cycles.
    always_comb begin
        cnt_d  = cnt_q;
        tout_d = tout_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ACCESS) && !pready && !tmo_hit) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (state_q == IDLE) begin
            tout_d = 1'b0;
        end else if (tmo_hit) begin
            tout_d = 1'b1;
        end
    end

    // Counter and timeout flag registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign rsp_timeout = tout_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = misaligned ? RESP : SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:   cmd_ready = rst_done_q;
            SETUP:  psel      = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command capture and response capture.
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if ((state_q == IDLE) && accept) begin
            write_d = cmd_write;
            addr_d  = cmd_addr;
            wdata_d = cmd_write ? cmd_wdata : '0;
            if (misaligned) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end else if ((state_q == ACCESS) && pready) begin
            rdata_d = write_q ? '0 : prdata;
            err_d   = pslverr;
        end else if (tmo_hit) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    // Datapath registers; reset clears everything including any pending command.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rst_done_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_filter_apb_mst.sv
// Directed self-checking bench for filter_apb_mst.
// Covers FILTER_APB_MST_TIMEOUT_EN both defined and undefined.
module tb_filter_apb_mst;
    import filter_apb_reg_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite, pready, pslverr, busy;
    logic [31:0] pwdata, prdata;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 pclk = ~pclk;

    filter_apb_mst #(.TIMEOUT_CYC(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    // Present a command for one cycle; returns in the cycle after acceptance.
    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        chk("issue_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int unsigned acc;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_psel",      {31'd0, psel},      32'd0);
        chk("rst_penable",   {31'd0, penable},   32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_paddr",     {24'd0, paddr},     32'd0);
        chk("rst_pwdata",    pwdata,             32'd0);
        chk("rst_rsp_rdata", rsp_rdata,          32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_rsp_tmo",   {31'd0, rsp_timeout}, 32'd0);
        presetn = 1'b1;
        #1 chk("rel_cmd_ready_before_clk", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("rel_cmd_ready_after_clk", {31'd0, cmd_ready}, 32'd1);

        // ---- write CTRL, zero wait states ----
        pready = 1'b1;
        issue(1'b1, CTRL_ADDR, 32'h1);
        chk("wr_setup_psel",    {31'd0, psel},    32'd1);
        chk("wr_setup_penable", {31'd0, penable}, 32'd0);
        chk("wr_setup_paddr",   {24'd0, paddr},   32'h10);
        chk("wr_setup_pwrite",  {31'd0, pwrite},  32'd1);
        chk("wr_setup_pwdata",  pwdata,           32'h1);
        chk("wr_setup_cmd_rdy", {31'd0, cmd_ready}, 32'd0);
        chk("wr_setup_busy",    {31'd0, busy},    32'd1);
        step();
        chk("wr_acc_psel",    {31'd0, psel},    32'd1);
        chk("wr_acc_penable", {31'd0, penable}, 32'd1);
        chk("wr_acc_paddr",   {24'd0, paddr},   32'h10);
        chk("wr_acc_pwdata",  pwdata,           32'h1);
        chk("wr_acc_rspv",    {31'd0, rsp_valid}, 32'd0);
        step();
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("wr_rsp_rdata", rsp_rdata,          32'd0);
        chk("wr_rsp_psel",  {31'd0, psel},      32'd0);
        chk("wr_rsp_pen",   {31'd0, penable},   32'd0);
        step();
        chk("wr_idle_rspv", {31'd0, rsp_valid}, 32'd0);
        chk("wr_idle_rdy",  {31'd0, cmd_ready}, 32'd1);
        chk("wr_idle_busy", {31'd0, busy},      32'd0);

        // ---- read ID with 3 wait states ----
        pready = 1'b0;
        issue(1'b0, ID_ADDR, 32'hFFFF_FFFF);
        chk("id_setup_pwdata", pwdata,          32'd0);
        chk("id_setup_pwrite", {31'd0, pwrite}, 32'd0);
        chk("id_setup_pen",    {31'd0, penable}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("id_acc_penable", {31'd0, penable}, 32'd1);
            chk("id_acc_paddr",   {24'd0, paddr},   32'hFC);
            chk("id_acc_pwdata",  pwdata,           32'd0);
            if (i == 4) begin
                pready = 1'b1;
                prdata = 32'h0000_020A;
            end
        end
        step();
        chk("id_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("id_rsp_rdata", rsp_rdata,          32'h0000_020A);
        chk("id_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("id_rsp_pen",   {31'd0, penable},   32'd0);
        prdata = '0;
        step();

        // ---- slave error ----
        pslverr = 1'b1;
        issue(1'b0, ERR_ADDR, 32'd0);
        step();
        step();
        chk("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("err_rsp_err",   {31'd0, rsp_err},   32'd1);
        pslverr = 1'b0;
        step();

        // ---- misaligned: no APB transfer ----
        issue(1'b1, 8'h15, 32'h55);
        chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mis_rsp_err",   {31'd0, rsp_err},   32'd1);
        chk("mis_rsp_rdata", rsp_rdata,          32'd0);
        chk("mis_psel",      {31'd0, psel},      32'd0);
        step();
        chk("mis_idle_psel", {31'd0, psel},      32'd0);

        // ---- response backpressure ----
        rsp_ready = 1'b0;
        prdata    = 32'h1234_5678;
        issue(1'b0, DATA_ADDR, 32'd0);
        step();
        step();
        prdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata,          32'h1234_5678);
            chk("bp_rsp_err",   {31'd0, rsp_err},   32'd0);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_rspv", {31'd0, rsp_valid}, 32'd0);
        issue(1'b1, CTRL_ADDR, 32'h2);
        chk("bp_next_psel",   {31'd0, psel}, 32'd1);
        chk("bp_next_pwdata", pwdata,        32'h2);
        step(); step(); step();
        prdata = '0;

`ifdef FILTER_APB_MST_TIMEOUT_EN
        // ---- timeout: pready stuck low ----
        pready = 1'b0;
        issue(1'b0, ID_ADDR, 32'd0);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (penable) acc++;
            else break;
        end
        chk("to_access_cycles", acc, 32'd16);
        chk("to_rsp_valid", {31'd0, rsp_valid},   32'd1);
        chk("to_rsp_err",   {31'd0, rsp_err},     32'd1);
        chk("to_rsp_tmo",   {31'd0, rsp_timeout}, 32'd1);
        chk("to_rsp_rdata", rsp_rdata,            32'd0);
        chk("to_psel",      {31'd0, psel},        32'd0);
        step();

        // ---- pready at the limit cycle wins ----
        issue(1'b0, ID_ADDR, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("lim_acc_penable", {31'd0, penable}, 32'd1);
            if (i == 16) begin
                pready = 1'b1;
                prdata = 32'h77;
            end
        end
        step();
        chk("lim_rsp_valid", {31'd0, rsp_valid},   32'd1);
        chk("lim_rsp_tmo",   {31'd0, rsp_timeout}, 32'd0);
        chk("lim_rsp_err",   {31'd0, rsp_err},     32'd0);
        chk("lim_rsp_rdata", rsp_rdata,            32'h77);
        step();
        prdata = '0;

        // enter a wait state for the reset test
        pready = 1'b0;
        issue(1'b0, DATA_ADDR, 32'd0);
        step();
        step();
`else
        // ---- no timeout: still waiting after 100 cycles ----
        pready = 1'b0;
        issue(1'b0, ID_ADDR, 32'd0);
        for (int i = 0; i < 100; i++) step();
        chk("nt_psel",      {31'd0, psel},        32'd1);
        chk("nt_penable",   {31'd0, penable},     32'd1);
        chk("nt_busy",      {31'd0, busy},        32'd1);
        chk("nt_rsp_valid", {31'd0, rsp_valid},   32'd0);
        chk("nt_rsp_tmo",   {31'd0, rsp_timeout}, 32'd0);
`endif

        // ---- reset during an ACCESS wait state ----
        chk("mr_pre_penable", {31'd0, penable}, 32'd1);
        #2 presetn = 1'b0;
        #1;
        chk("mr_psel",      {31'd0, psel},      32'd0);
        chk("mr_penable",   {31'd0, penable},   32'd0);
        chk("mr_busy",      {31'd0, busy},      32'd0);
        chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step(); step();
        presetn = 1'b1;
        pready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mr_post_rspv", {31'd0, rsp_valid}, 32'd0);
            chk("mr_post_psel", {31'd0, psel},      32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
